branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be synchronous and active-high: `clk` input 1, rising-edge clock; `reset` input 1, synchronous active-high reset.
REQ-002 The block SHALL expose the following ports, one per line (name, direction, width, meaning):
- `stall`  in  1  hazard hold; freezes the PC and suppresses resolution.
- `id_pc`  in  64  PC of the instruction currently in decode.
- `br_uncond`  in  1  decode holds B.
- `br_cbz`  in  1  decode holds CBZ.
- `br_cond`  in  1  decode holds B.cond.
- `cond_code`  in  4  B.cond condition field Rt[3:0].
- `brAddr26`  in  26  B offset, in words.
- `condAddr19`  in  19  CBZ/B.cond offset, in words.
- `CBZ_zeroFlag`  in  1  from the decode-stage zero detector; 1 when the Rt operand is zero.
- `ex_setflags`  in  1  the execute-stage instruction writes flags this cycle.
- `ex_neg`, `ex_zero`, `ex_ovf`, `ex_cout`  in  1 each  ALU flags from execute.
- `pc`  out  64  current fetch address (registered).
- `br_taken`  out  1  a branch in decode resolves taken this cycle.
- `flush_ifid`  out  1  squash the IF/ID contents.
- `flags_q`  out  4  architectural NZVC register, {N,Z,V,C}.
- `taken_count`  out  32  number of taken branches since reset.

Function
REQ-003 The block SHALL decode at most one branch kind at a time; `br_uncond`, `br_cbz` and `br_cond` are mutually exclusive (the bench asserts this).
REQ-004 The block SHALL compute the branch target as `id_pc` + (sign-extended offset << 2):
- offset = `brAddr26` for B, `condAddr19` otherwise.
- Arithmetic is 64-bit with wrap-around modulo 2^64 and no overflow detection.
REQ-005 The block SHALL use effective flags equal to the `ex_*` flags when `ex_setflags`=1 (same-cycle forwarding), else `flags_q`.
REQ-006 The block SHALL evaluate the B.cond condition on the effective flags:
- 0 EQ: Z.
- 1 NE: !Z.
- 2 HS: C.
- 3 LO: !C.
- 4 MI: N.
- 5 PL: !N.
- 6 VS: V.
- 7 VC: !V.
- 8 HI: C&!Z.
- 9 LS: !(C&!Z).
- 10 GE: N==V.
- 11 LT: N!=V.
- 12 GT: !Z&(N==V).
- 13 LE: !(!Z&(N==V)).
- 14/15: always.
REQ-007 The block SHALL drive `br_taken` (combinational) = !`stall` & (`br_uncond` | (`br_cbz` & `CBZ_zeroFlag`) | (`br_cond` & cond_true)).
REQ-008 The block SHALL drive `flush_ifid` = `br_taken`, with zero cycles of latency.
REQ-009 On each rising edge with `reset`=0, the block SHALL update `pc` as follows:
- `stall`=1: hold.
- else `br_taken`: `pc` <= target.
- else: `pc` <= `pc` + 4, wrapping modulo 2^64.
REQ-010 The block SHALL apply the 1-cycle redirect: a taken branch resolved in cycle N SHALL make `pc`=target visible in cycle N+1.
REQ-011 On each rising edge with `reset`=0 and `ex_setflags`=1, the block SHALL update `flags_q` <= {`ex_neg`,`ex_zero`,`ex_ovf`,`ex_cout`}. This update is independent of `stall`.
REQ-012 On each rising edge where `br_taken`=1, the block SHALL increment `taken_count` by 1, wrapping from 0xFFFFFFFF to 0.
REQ-013 While `stall`=1, the block SHALL NOT resolve a branch; a branch held in decode across stall cycles SHALL resolve exactly once, in the first cycle after `stall` falls.
REQ-014 When `stall` and a branch condition coincide, the block SHALL give `stall` priority: `br_taken`=0, `flush_ifid`=0, the PC held and the counter unchanged.
REQ-015 The block SHALL contain no other state; all outputs other than `br_taken` and `flush_ifid` are register outputs.

Reset
REQ-016 On a rising edge with `reset`=1, the block SHALL set `pc`=0, `flags_q`=4'b0000 and `taken_count`=0, regardless of `stall` or branch inputs.
REQ-017 While `reset`=1, the combinational outputs SHALL still follow REQ-007/REQ-008. Any redirect computed in a reset cycle SHALL be discarded.
REQ-018 When reset is asserted mid-stall or mid-branch, the block SHALL discard the pending stall or branch. After reset deasserts, the first edge SHALL give `pc`=4.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then 3 idle cycles -> `pc` 0,4,8,12; `taken_count`=0; `br_taken`=0 throughout.
- `id_pc`=0x100, `br_cbz`=1, `condAddr19`=0x7FFFF (-1), `CBZ_zeroFlag`=1 -> `br_taken`=1, `flush_ifid`=1, next `pc`=0xFC, `taken_count`=1. The same case with `CBZ_zeroFlag`=0 -> not taken, `pc`+4.
- `ex_setflags`=1 with `ex_zero`=1 in the same cycle as `br_cond`, `cond_code`=0 (EQ), while `flags_q`.Z=0 -> taken via forwarding; next cycle `flags_q`=4'b0100.
- `br_uncond` held with `stall`=1 for 2 cycles, then `stall`=0 -> `pc` frozen 2 cycles, `br_taken` asserted exactly once, `taken_count` +1.
- `cond_code`=10 (GE) with flags N=1,V=1 -> taken; with N=1,V=0 -> not taken; `cond_code`=15 -> taken.
- `id_pc`=0xFFFFFFFFFFFFFFFC, B with `brAddr26`=1 -> `pc`=0 (wrap). `taken_count` preloaded to 0xFFFFFFFF by 2^32 iterations is not required; its wrap is checked via a forced-value test.

Source files
------------

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_unit
//  Description : Decode-stage branch resolution. Computes branch targets,
//                evaluates CBZ / B.cond against forwarded NZVC flags, and
//                redirects the fetch PC one cycle after a taken branch.
//                Also holds the architectural flag register and a
//                taken-branch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [63:0] id_pc,
  input  logic        br_uncond,
  input  logic        br_cbz,
  input  logic        br_cond,
  input  logic [3:0]  cond_code,
  input  logic [25:0] brAddr26,
  input  logic [18:0] condAddr19,
  input  logic        CBZ_zeroFlag,
  input  logic        ex_setflags,
  input  logic        ex_neg,
  input  logic        ex_zero,
  input  logic        ex_ovf,
  input  logic        ex_cout,
  output logic [63:0] pc,
  output logic        br_taken,
  output logic        flush_ifid,
  output logic [3:0]  flags_q,
  output logic [31:0] taken_count
);

  logic [63:0] r_pc;
  logic [3:0]  r_flags;
  logic [31:0] r_taken_count;

  logic [63:0] w_offset_bytes;
  logic [63:0] w_target;
  logic [3:0]  w_eff_flags;
  logic        w_n, w_z, w_v, w_c;
  logic        w_cond_true;
  logic        w_taken;

  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign w_offset_bytes = br_uncond ? {{36{brAddr26[25]}}, brAddr26, 2'b00}
                                    : {{43{condAddr19[18]}}, condAddr19, 2'b00};
  assign w_target       = id_pc + w_offset_bytes;

  // An execute-stage flag write is forwarded so B.cond sees it the same cycle.
  assign w_eff_flags = ex_setflags ? {ex_neg, ex_zero, ex_ovf, ex_cout} : r_flags;
  assign w_n = w_eff_flags[3];
  assign w_z = w_eff_flags[2];
  assign w_v = w_eff_flags[1];
  assign w_c = w_eff_flags[0];

  // Condition-code evaluation on the effective flags.
  always_comb begin
    w_cond_true = 1'b0;
    case (cond_code)
      4'd0:    w_cond_true = w_z;
      4'd1:    w_cond_true = !w_z;
      4'd2:    w_cond_true = w_c;
      4'd3:    w_cond_true = !w_c;
      4'd4:    w_cond_true = w_n;
      4'd5:    w_cond_true = !w_n;
      4'd6:    w_cond_true = w_v;
      4'd7:    w_cond_true = !w_v;
      4'd8:    w_cond_true = w_c && !w_z;
      4'd9:    w_cond_true = !(w_c && !w_z);
      4'd10:   w_cond_true = (w_n == w_v);
      4'd11:   w_cond_true = (w_n != w_v);
      4'd12:   w_cond_true = !w_z && (w_n == w_v);
      4'd13:   w_cond_true = !(!w_z && (w_n == w_v));
      default: w_cond_true = 1'b1;
    endcase
  end

  // Stall has priority: a held branch resolves only once the hazard clears.
  assign w_taken = !stall && (br_uncond || (br_cbz && CBZ_zeroFlag) || (br_cond && w_cond_true));

  // PC: hold on stall, redirect on taken branch, otherwise sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= 64'd0;
    end else if (!stall) begin
      r_pc <= w_taken ? w_target : (r_pc + 64'd4);
    end
  end

  // Flag register follows execute writes regardless of stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (ex_setflags) begin
      r_flags <= {ex_neg, ex_zero, ex_ovf, ex_cout};
    end
  end

  // Taken-branch counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_count <= 32'd0;
    end else if (w_taken) begin
      r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign pc          = r_pc;
  assign flags_q     = r_flags;
  assign taken_count = r_taken_count;
  assign br_taken    = w_taken;
  assign flush_ifid  = w_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_unit
//  Description : Self-checking bench for branch_unit. A behavioural model of
//                the fetch PC, flag register and taken counter is compared
//                against the DUT every cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [63:0] id_pc;
  logic        br_uncond, br_cbz, br_cond;
  logic [3:0]  cond_code;
  logic [25:0] brAddr26;
  logic [18:0] condAddr19;
  logic        CBZ_zeroFlag, ex_setflags, ex_neg, ex_zero, ex_ovf, ex_cout;
  logic [63:0] pc;
  logic        br_taken, flush_ifid;
  logic [3:0]  flags_q;
  logic [31:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [63:0] m_pc;
  logic [3:0]  m_flags;
  logic [31:0] m_count;
  bit          m_valid = 1'b0;

  branch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .id_pc(id_pc),
    .br_uncond(br_uncond), .br_cbz(br_cbz), .br_cond(br_cond),
    .cond_code(cond_code), .brAddr26(brAddr26), .condAddr19(condAddr19),
    .CBZ_zeroFlag(CBZ_zeroFlag), .ex_setflags(ex_setflags),
    .ex_neg(ex_neg), .ex_zero(ex_zero), .ex_ovf(ex_ovf), .ex_cout(ex_cout),
    .pc(pc), .br_taken(br_taken), .flush_ifid(flush_ifid),
    .flags_q(flags_q), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each condition code.
  function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, v, c;
    {n, z, v, c} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !(c && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_taken();
    logic [3:0] eff;
    eff = ex_setflags ? {ex_neg, ex_zero, ex_ovf, ex_cout} : m_flags;
    if (stall) return 1'b0;
    return br_uncond || (br_cbz && CBZ_zeroFlag) || (br_cond && cond_holds(cond_code, eff));
  endfunction

  function automatic logic [63:0] model_target();
    longint off;
    off = br_uncond ? longint'($signed(brAddr26)) : longint'($signed(condAddr19));
    return id_pc + 64'(off * 4);
  endfunction

  // Model advances on each rising edge using the inputs present at the edge.
  always @(posedge clk) begin
    bit          t;
    logic [63:0] tgt;
    t   = model_taken();
    tgt = model_target();
    if (reset) begin
      m_pc = 64'd0; m_flags = 4'b0; m_count = 32'd0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (!stall) m_pc = t ? tgt : m_pc + 64'd4;
      if (ex_setflags) m_flags = {ex_neg, ex_zero, ex_ovf, ex_cout};
      if (t) m_count = m_count + 32'd1;
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      assert ($onehot0({br_uncond, br_cbz, br_cond})) else $error("branch kinds not exclusive");
      chk("pc", pc, m_pc);
      chk("flags_q", 64'(flags_q), 64'(m_flags));
      chk("taken_count", 64'(taken_count), 64'(m_count));
      chk("br_taken", 64'(br_taken), 64'(model_taken()));
      chk("flush_ifid", 64'(flush_ifid), 64'(model_taken()));
    end
  end

  task automatic clear_inputs();
    stall = 0; id_pc = 0; br_uncond = 0; br_cbz = 0; br_cond = 0; cond_code = 0;
    brAddr26 = 0; condAddr19 = 0; CBZ_zeroFlag = 0; ex_setflags = 0;
    ex_neg = 0; ex_zero = 0; ex_ovf = 0; ex_cout = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] held_pc;

  initial begin
    clear_inputs();
    reset = 1;
    step(); step();
    chk("rst_pc", pc, 64'd0);
    chk("rst_count", 64'(taken_count), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    reset = 0;
    #1;
    chk("rst_pc_hold", pc, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("idle_pc", pc, 64'(4 * i));
      chk("idle_taken", 64'(br_taken), 64'd0);
    end

    // CBZ backward by one word, taken then not taken
    id_pc = 64'h100; br_cbz = 1; condAddr19 = 19'h7FFFF; CBZ_zeroFlag = 1;
    #1;
    chk("cbz_taken", 64'(br_taken), 64'd1);
    chk("cbz_flush", 64'(flush_ifid), 64'd1);
    step();
    chk("cbz_pc", pc, 64'hFC);
    chk("cbz_count", 64'(taken_count), 64'd1);
    CBZ_zeroFlag = 0;
    #1;
    chk("cbz_nt", 64'(br_taken), 64'd0);
    step();
    chk("cbz_nt_pc", pc, 64'h100);
    br_cbz = 0;

    // EQ resolved through same-cycle flag forwarding
    br_cond = 1; cond_code = 4'd0; ex_setflags = 1; ex_zero = 1;
    #1;
    chk("fwd_taken", 64'(br_taken), 64'd1);
    step();
    chk("fwd_flags", 64'(flags_q), 64'b0100);
    chk("fwd_pc", pc, 64'hFC);
    clear_inputs();

    // B held across two stall cycles
    id_pc = 64'h200; br_uncond = 1; brAddr26 = 26'd4; stall = 1;
    #1;
    held_pc = pc;
    chk("stall_nt", 64'(br_taken), 64'd0);
    step();
    chk("stall_pc1", pc, held_pc);
    step();
    chk("stall_pc2", pc, held_pc);
    chk("stall_count", 64'(taken_count), 64'd2);
    stall = 0;
    #1;
    chk("unstall_taken", 64'(br_taken), 64'd1);
    step();
    chk("unstall_pc", pc, 64'h210);
    br_uncond = 0;
    step();
    chk("once_count", 64'(taken_count), 64'd3);
    chk("once_pc", pc, 64'h214);

    // GE / AL
    ex_setflags = 1; ex_neg = 1; ex_ovf = 1; ex_zero = 0; ex_cout = 0;
    step();
    chk("ge_flags", 64'(flags_q), 64'b1010);
    ex_setflags = 0; br_cond = 1; cond_code = 4'd10;
    #1;
    chk("ge_nv11", 64'(br_taken), 64'd1);
    ex_setflags = 1; ex_ovf = 0;
    #1;
    chk("ge_nv10", 64'(br_taken), 64'd0);
    cond_code = 4'd15;
    #1;
    chk("al_taken", 64'(br_taken), 64'd1);
    clear_inputs();
    #1;

    // Target wraps past 2^64
    id_pc = 64'hFFFF_FFFF_FFFF_FFFC; br_uncond = 1; brAddr26 = 26'd1;
    step();
    chk("wrap_pc", pc, 64'd0);
    clear_inputs();

    // Counter wrap from a forced all-ones value
    force dut.r_taken_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_taken_count;
    m_count = 32'hFFFF_FFFF;
    br_uncond = 1; brAddr26 = 26'd2; id_pc = 64'h40;
    step();
    chk("cnt_wrap", 64'(taken_count), 64'd0);
    clear_inputs();

    // Reset during a stalled branch discards it
    stall = 1; br_uncond = 1; brAddr26 = 26'd8; reset = 1;
    step();
    chk("rst_mid_pc", pc, 64'd0);
    reset = 0; clear_inputs();
    step();
    chk("rst_after_pc", pc, 64'd4);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      int kind;
      reset        = ($urandom_range(0, 99) < 2);
      stall        = ($urandom_range(0, 99) < 25);
      id_pc        = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) id_pc[63:8] = {56{id_pc[7]}};
      kind         = $urandom_range(0, 3);
      br_uncond    = (kind == 1);
      br_cbz       = (kind == 2);
      br_cond      = (kind == 3);
      cond_code    = 4'($urandom);
      brAddr26     = 26'($urandom);
      condAddr19   = 19'($urandom);
      CBZ_zeroFlag = 1'($urandom);
      ex_setflags  = 1'($urandom);
      {ex_neg, ex_zero, ex_ovf, ex_cout} = 4'($urandom);
      step();
    end
    reset = 0; clear_inputs();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
